fnd_game_timer: RTL and testbench

FND_GAME_TIMER -- requirements
Module: fnd_game_timer

---
 rtl/fnd_game_timer.sv | 194 +++++++++++++++++++
 tb/tb_fnd_game_timer.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fnd_game_timer.sv
// fnd_game_timer: BCD game timer with IDLE/RUN/PAUSED control, score latch
// and a multiplexed active-low 7-segment scan with leading-zero blanking.
// Optional build macro FND_GAME_TIMER_SAT_EN: saturate at all-9s instead of
// wrapping to all-0s.
module fnd_game_timer #(
  parameter int P_DIGITS  = 3,
  parameter int P_TICK    = 99_999_999,
  parameter int P_SCAN    = 99_999,
  parameter int P_SCORE_W = 14
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst,
  input  logic                  i_Start,
  input  logic                  i_Stop,
  input  logic                  i_Clear,
  input  logic [P_SCORE_W-1:0]  i_Score,
  output logic [4*P_DIGITS-1:0] o_Digit,
  output logic [P_SCORE_W-1:0]  o_Score,
  output logic [6:0]            o_Seg,
  output logic [P_DIGITS-1:0]   o_Sel,
  output logic                  o_Running,
  output logic                  o_Wrap
);

  localparam int TICK_W = (P_TICK < 1) ? 1 : $clog2(P_TICK + 1);
  localparam int SCAN_W = (P_SCAN < 1) ? 1 : $clog2(P_SCAN + 1);
  localparam int IDX_W  = (P_DIGITS < 2) ? 1 : $clog2(P_DIGITS);

  localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(P_TICK);
  localparam logic [SCAN_W-1:0] SCAN_MAX = SCAN_W'(P_SCAN);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(P_DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } state_t;

  state_t                state;
  state_t                next_state;
  logic                  running;
  logic [TICK_W-1:0]     tick;
  logic [4*P_DIGITS-1:0] digits;
  logic [4*P_DIGITS-1:0] digits_inc;
  logic [4*P_DIGITS-1:0] digits_cnt;
  logic                  carry;
  logic                  wrap_cnt;
  logic [P_SCORE_W-1:0]  score;
  logic                  wrap;
  logic [SCAN_W-1:0]     scan_cnt;
  logic [IDX_W-1:0]      idx;
  logic [P_DIGITS-1:0]   blank;
  logic                  zero_above;
  logic [3:0]            sel_digit;
  logic [6:0]            seg;
  logic [P_DIGITS-1:0]   sel;
`ifdef FND_GAME_TIMER_SAT_EN
  logic                  inc_all_nine;
`endif

  // State register; running flag registered alongside it.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state   <= IDLE;
      running <= 1'b0;
    end else begin
      state   <= next_state;
      running <= (next_state == RUN);
    end
  end

  // Next state: clear beats stop beats start; a high stop also blocks resume.
  always_comb begin
    next_state = state;
    if (i_Clear) begin
      next_state = IDLE;
    end else if (i_Stop) begin
      if (state == RUN) next_state = PAUSED;
    end else if (i_Start) begin
      if (state != RUN) next_state = RUN;
    end
  end

  // Ripple-decimal increment of the whole digit vector and count outcome.
  always_comb begin
    digits_inc = digits;
    carry      = 1'b1;
    for (int unsigned k = 0; k < P_DIGITS; k++) begin
      if (carry) begin
        if (digits[4*k +: 4] == 4'd9) begin
          digits_inc[4*k +: 4] = 4'd0;
        end else begin
          digits_inc[4*k +: 4] = digits[4*k +: 4] + 4'd1;
          carry                = 1'b0;
        end
      end
    end
`ifdef FND_GAME_TIMER_SAT_EN
    inc_all_nine = 1'b1;
    for (int unsigned k = 0; k < P_DIGITS; k++) begin
      if (digits_inc[4*k +: 4] != 4'd9) inc_all_nine = 1'b0;
    end
    // carry out set means every digit is already 9: hold, no further pulse
    digits_cnt = carry ? digits : digits_inc;
    wrap_cnt   = !carry && inc_all_nine;
`else
    digits_cnt = digits_inc;
    wrap_cnt   = carry;
`endif
  end

  // Tick counter, digits, score latch and wrap pulse.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      tick   <= '0;
      digits <= '0;
      score  <= '0;
      wrap   <= 1'b0;
    end else if (i_Clear) begin
      tick   <= '0;
      digits <= '0;
      score  <= '0;
      wrap   <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (state == RUN) begin
        // The stop edge still counts, so the held value is the advanced one.
        if (tick == TICK_MAX) begin
          tick   <= '0;
          digits <= digits_cnt;
          wrap   <= wrap_cnt;
          score  <= i_Score;
        end else begin
          tick <= tick + TICK_W'(1);
        end
        if (i_Stop) score <= i_Score;
      end
    end
  end

  // Scan slot counter and digit index, free-running in every state.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      scan_cnt <= '0;
      idx      <= '0;
    end else if (scan_cnt == SCAN_MAX) begin
      scan_cnt <= '0;
      idx      <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
    end else begin
      scan_cnt <= scan_cnt + SCAN_W'(1);
    end
  end

  // Leading-zero blank mask, walking from the most significant digit down.
  always_comb begin
    blank      = '0;
    zero_above = 1'b1;
    for (int unsigned j = 0; j < P_DIGITS; j++) begin
      zero_above = zero_above && (digits[4*(P_DIGITS-1-j) +: 4] == 4'd0);
      blank[P_DIGITS-1-j] = zero_above && (j != unsigned'(P_DIGITS - 1));
    end
  end

  // Segment decode and active-low select for the scanned digit.
  always_comb begin
    sel_digit = digits[4*idx +: 4];
    sel       = '1;
    sel[idx]  = 1'b0;
    seg       = 7'b1111111;
    if (!blank[idx]) begin
      case (sel_digit)
        4'd0:    seg = 7'b1000000;
        4'd1:    seg = 7'b1111001;
        4'd2:    seg = 7'b0100100;
        4'd3:    seg = 7'b0110000;
        4'd4:    seg = 7'b0011001;
        4'd5:    seg = 7'b0010010;
        4'd6:    seg = 7'b0000010;
        4'd7:    seg = 7'b1111000;
        4'd8:    seg = 7'b0000000;
        4'd9:    seg = 7'b0010000;
        default: seg = 7'b1111111;
      endcase
    end
  end

  assign o_Digit   = digits;
  assign o_Score   = score;
  assign o_Seg     = seg;
  assign o_Sel     = sel;
  assign o_Running = running;
  assign o_Wrap    = wrap;

endmodule

// File: tb/tb_fnd_game_timer.sv
// Testbench for fnd_game_timer: arithmetic reference model (timer value as a
// plain integer, scan slot from elapsed clocks) checked every cycle, plus
// directed scenarios with literal expectations and a randomized phase.
module tb_fnd_game_timer;

  localparam int P_DIGITS  = 3;
  localparam int P_TICK    = 9;
  localparam int P_SCAN    = 2;
  localparam int P_SCORE_W = 14;

  logic        i_Clk;
  logic        i_Rst;
  logic        i_Start;
  logic        i_Stop;
  logic        i_Clear;
  logic [13:0] i_Score;
  logic [11:0] o_Digit;
  logic [13:0] o_Score;
  logic [6:0]  o_Seg;
  logic [2:0]  o_Sel;
  logic        o_Running;
  logic        o_Wrap;

  fnd_game_timer #(
    .P_DIGITS (P_DIGITS),
    .P_TICK   (P_TICK),
    .P_SCAN   (P_SCAN),
    .P_SCORE_W(P_SCORE_W)
  ) dut (
    .i_Clk    (i_Clk),
    .i_Rst    (i_Rst),
    .i_Start  (i_Start),
    .i_Stop   (i_Stop),
    .i_Clear  (i_Clear),
    .i_Score  (i_Score),
    .o_Digit  (o_Digit),
    .o_Score  (o_Score),
    .o_Seg    (o_Seg),
    .o_Sel    (o_Sel),
    .o_Running(o_Running),
    .o_Wrap   (o_Wrap)
  );

  initial i_Clk = 1'b0;
  always #5 i_Clk = ~i_Clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic int pow10(input int k);
    int p;
    p = 1;
    repeat (k) p = p * 10;
    return p;
  endfunction

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0:       return 7'b1000000;
      1:       return 7'b1111001;
      2:       return 7'b0100100;
      3:       return 7'b0110000;
      4:       return 7'b0011001;
      5:       return 7'b0010010;
      6:       return 7'b0000010;
      7:       return 7'b1111000;
      8:       return 7'b0000000;
      9:       return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Reference model: mode 0=idle 1=run 2=paused, timer value as an integer.
  bit          mvalid = 1'b0;
  int          m_mode;
  int          m_val;
  int          m_tick;
  int          m_scan;
  logic [13:0] m_score;
  bit          m_wrap;
  int          max_val;

  initial max_val = pow10(P_DIGITS) - 1;

  always @(posedge i_Clk) begin
    if (i_Rst) begin
      mvalid  = 1'b1;
      m_mode  = 0;
      m_val   = 0;
      m_tick  = 0;
      m_scan  = 0;
      m_score = '0;
      m_wrap  = 1'b0;
    end else if (mvalid) begin
      m_scan++;
      m_wrap = 1'b0;
      if (i_Clear) begin
        m_mode  = 0;
        m_val   = 0;
        m_tick  = 0;
        m_score = '0;
      end else if (m_mode == 1) begin
        m_tick++;
        if (m_tick == P_TICK + 1) begin
          m_tick  = 0;
          m_score = i_Score;
`ifdef FND_GAME_TIMER_SAT_EN
          if (m_val != max_val) begin
            m_val++;
            if (m_val == max_val) m_wrap = 1'b1;
          end
`else
          if (m_val == max_val) begin
            m_val  = 0;
            m_wrap = 1'b1;
          end else begin
            m_val++;
          end
`endif
        end
        if (i_Stop) begin
          m_score = i_Score;
          m_mode  = 2;
        end
      end else if (i_Start && !i_Stop) begin
        m_mode = 1;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge i_Clk) begin
    int          k;
    logic [11:0] e_digit;
    logic [6:0]  e_seg;
    logic [2:0]  e_sel;
    if (mvalid) begin
      k = (m_scan / (P_SCAN + 1)) % P_DIGITS;
      e_digit = 12'(((m_val / 100) % 10) * 256 + ((m_val / 10) % 10) * 16 + (m_val % 10));
      e_seg = (k > 0 && m_val < pow10(k)) ? 7'b1111111 : seg_of((m_val / pow10(k)) % 10);
      e_sel = ~(3'b001 << k);
      check("model_digit",   o_Digit,   e_digit);
      check("model_score",   o_Score,   m_score);
      check("model_seg",     o_Seg,     e_seg);
      check("model_sel",     o_Sel,     e_sel);
      check("model_running", o_Running, (m_mode == 1));
      check("model_wrap",    o_Wrap,    m_wrap);
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic next_cyc();
    @(negedge i_Clk);
    #1;
  endtask

  initial begin
    logic [13:0] sc;
    logic [2:0]  prev_sel;
    int          waited;
    int          nw;
    int          wrap_at;
    bit          aligned;

    i_Rst = 1'b1; i_Start = 1'b0; i_Stop = 1'b0; i_Clear = 1'b0; i_Score = '0;
    next_cyc();
    next_cyc();
    i_Rst = 1'b0;
    check("rst_digit",   o_Digit,   12'h000);
    check("rst_sel",     o_Sel,     3'b110);
    check("rst_seg",     o_Seg,     7'b1000000);
    check("rst_running", o_Running, 1'b0);
    check("rst_wrap",    o_Wrap,    1'b0);
    check("rst_score",   o_Score,   14'd0);

    // Start, 30 clocks -> three counts.
    i_Score = 14'(($urandom));
    i_Start = 1'b1;
    next_cyc();
    i_Start = 1'b0;
    repeat (30) next_cyc();
    check("run30_digit",   o_Digit,   12'h003);
    check("run30_running", o_Running, 1'b1);

    // Pause with tick at 5; resume continues the partial count.
    repeat (5) next_cyc();
    sc = 14'($urandom);
    i_Score = sc;
    i_Stop = 1'b1;
    next_cyc();
    i_Stop = 1'b0;
    i_Score = ~sc;
    repeat (50) next_cyc();
    check("pause_score",   o_Score,   sc);
    check("pause_running", o_Running, 1'b0);
    check("pause_digit",   o_Digit,   12'h003);
    i_Start = 1'b1;
    next_cyc();
    i_Start = 1'b0;
    repeat (3) next_cyc();
    check("resume_3clk", o_Digit, 12'h003);
    next_cyc();
    check("resume_4clk", o_Digit, 12'h004);

    // All three requests in RUN -> clear wins.
    i_Start = 1'b1; i_Stop = 1'b1; i_Clear = 1'b1;
    next_cyc();
    i_Start = 1'b0; i_Stop = 1'b0; i_Clear = 1'b0;
    check("all3_digit",   o_Digit,   12'h000);
    check("all3_score",   o_Score,   14'd0);
    check("all3_running", o_Running, 1'b0);
    i_Start = 1'b1;
    next_cyc();
    i_Start = 1'b0;
    repeat (4) next_cyc();
    i_Stop = 1'b1;
    next_cyc();
    i_Stop = 1'b0;
    i_Start = 1'b1; i_Stop = 1'b1;
    next_cyc();
    i_Start = 1'b0; i_Stop = 1'b0;
    check("paused_startstop", o_Running, 1'b0);
    repeat (2) next_cyc();
    check("paused_hold", o_Running, 1'b0);

    // Reach 007, freeze, then watch one full scan cycle.
    i_Clear = 1'b1;
    next_cyc();
    i_Clear = 1'b0;
    i_Start = 1'b1;
    next_cyc();
    i_Start = 1'b0;
    repeat (70) next_cyc();
    i_Stop = 1'b1;
    next_cyc();
    i_Stop = 1'b0;
    check("scan_digit", o_Digit, 12'h007);
    aligned = 1'b0;
    waited  = 0;
    while (!aligned && waited < 20) begin
      prev_sel = o_Sel;
      next_cyc();
      waited++;
      if (prev_sel == 3'b011 && o_Sel == 3'b110) aligned = 1'b1;
    end
    check("scan_align", aligned, 1'b1);
    for (int j = 0; j < 9; j++) begin
      if (j > 0) next_cyc();
      check("scan_sel", o_Sel, (j < 3) ? 3'b110 : (j < 6) ? 3'b101 : 3'b011);
      check("scan_seg", o_Seg, (j < 3) ? 7'b1111000 : 7'b1111111);
    end

    // Run up to 998, then across the top of the range.
    i_Clear = 1'b1;
    next_cyc();
    i_Clear = 1'b0;
    i_Start = 1'b1;
    next_cyc();
    i_Start = 1'b0;
    waited = 0;
    while (o_Digit !== 12'h998 && waited < 11000) begin
      next_cyc();
      waited++;
    end
    check("reach_998", o_Digit, 12'h998);
    nw = 0;
    wrap_at = 0;
    for (int i = 1; i <= 20; i++) begin
      next_cyc();
      if (o_Wrap === 1'b1) begin
        nw++;
        if (wrap_at == 0) wrap_at = i;
      end
      if (i == 10) check("top_999", o_Digit, 12'h999);
    end
    check("top_wrap_count", nw, 1);
    check("top_running", o_Running, 1'b1);
`ifdef FND_GAME_TIMER_SAT_EN
    check("top_end", o_Digit, 12'h999);
    check("top_wrap_at", wrap_at, 10);
`else
    check("top_end", o_Digit, 12'h000);
    check("top_wrap_at", wrap_at, 20);
`endif

    // Randomized control traffic, including mid-count resets.
    for (int c = 0; c < 3000; c++) begin
      i_Score = 14'($urandom);
      i_Start = ($urandom_range(0, 3) == 0);
      i_Stop  = ($urandom_range(0, 31) == 0);
      i_Clear = ($urandom_range(0, 127) == 0);
      i_Rst   = ($urandom_range(0, 511) == 0);
      next_cyc();
    end
    i_Start = 1'b0; i_Stop = 1'b0; i_Clear = 1'b0; i_Rst = 1'b0;
    repeat (3) next_cyc();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
